// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
//
// Output stage of the multi-core processor. When the cores report completion,
// it reads a contiguous block of result words from data memory and streams
// them one word per clock on com_data_out. Each valid word is framed by
// output_write_start, and the final word also carries output_write_done.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   process_done        cores finished (sampled only while idle)
//   out_base_addr       first result address, latched on start
//   out_length          words to emit (0..2^ADDR_WIDTH), latched on start
//   mem_rd_en           memory read strobe
//   mem_rd_addr         memory read address (wraps modulo 2^ADDR_WIDTH)
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   com_data_out        registered output word
//   output_write_start  com_data_out carries a valid word
//   output_write_done   com_data_out carries the final word
//   busy                a run is in progress
// -----------------------------------------------------------------------------
module result_streamer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  process_done,
    input  logic [ADDR_WIDTH-1:0] out_base_addr,
    input  logic [ADDR_WIDTH:0]   out_length,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] com_data_out,
    output logic                  output_write_start,
    output logic                  output_write_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   emit_cnt;
    logic                  zero_q;   // zero-length framing token, one cycle after start
    logic                  v1;       // stage 1 valid, aligned with mem_rd_data
    logic                  z1;       // stage 1 carries the zero-length token

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave a value unassigned and infer a latch.
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (process_done) begin
                    start      = 1'b1;
                    state_next = (out_length == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue_cnt == len_q - ONE) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final word is on the output now; idle from the next cycle.
                if (output_write_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy        = (state != IDLE);
    assign mem_rd_en   = (state == READ);
    assign mem_rd_addr = base_q + issue_cnt[ADDR_WIDTH-1:0];

    // -------------------------------------------------------------------------
    // Run parameters and issue counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            zero_q    <= 1'b0;
        end else begin
            zero_q <= 1'b0;
            if (start) begin
                base_q    <= out_base_addr;
                len_q     <= out_length;
                issue_cnt <= '0;
                zero_q    <= (out_length == '0);
            end else if (mem_rd_en) begin
                issue_cnt <= issue_cnt + ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline and output framing. The zero-length token rides the same
    // pipeline as a real read so its framing cycle lands at the usual latency.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1                 <= 1'b0;
            z1                 <= 1'b0;
            emit_cnt           <= '0;
            com_data_out       <= '0;
            output_write_start <= 1'b0;
            output_write_done  <= 1'b0;
        end else begin
            v1                 <= mem_rd_en | zero_q;
            z1                 <= zero_q;
            output_write_start <= v1;
            // emit_cnt holds the index of the word loading now.
            output_write_done  <= v1 & (z1 | (emit_cnt == len_q - ONE));
            if (start) begin
                emit_cnt <= '0;
            end else if (v1) begin
                emit_cnt <= emit_cnt + ONE;
            end
            if (v1) begin
                com_data_out <= z1 ? '0 : mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_streamer
//
// Directed bench for result_streamer. Stimulus pushes the hand-computed
// expected words (data, done flag, cycle) into a queue; an independent
// monitor pops and compares whenever output_write_start is high.
// -----------------------------------------------------------------------------
module tb_result_streamer;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          process_done;
    logic [AW-1:0] out_base_addr;
    logic [AW:0]   out_length;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] com_data_out;
    logic          output_write_start;
    logic          output_write_done;
    logic          busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          done;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] rd_log[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            cyc;
    int            rd_count;
    int            checks;
    int            failures;

    result_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .process_done       (process_done),
        .out_base_addr      (out_base_addr),
        .out_length         (out_length),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_data        (mem_rd_data),
        .com_data_out       (com_data_out),
        .output_write_start (output_write_start),
        .output_write_done  (output_write_done),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] data, input logic done, input int at);
        exp_t e;
        e.data = data;
        e.done = done;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_count++;
            rd_log.push_back(mem_rd_addr);
        end
        if (output_write_done && !output_write_start)
            check("done_without_start", 32'(output_write_done), 32'd0);
        if (output_write_start) begin
            check("start_implies_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(com_data_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data", 32'(com_data_out), 32'(e.data));
                check("word_done", 32'(output_write_done), 32'(e.done));
                check("word_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue a start at the current falling edge. tq is the sampling edge;
    // returns at the falling edge right after it.
    task automatic launch(input logic [AW-1:0] base, input logic [AW:0] len, output int tq);
        out_base_addr = base;
        out_length    = len;
        process_done  = 1'b1;
        tq            = cyc + 1;
        @(negedge clk);
        process_done  = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
        if (cyc < target) check("wait_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_start"}, 32'(output_write_start), 32'd0);
        check({name, "_done"}, 32'(output_write_done), 32'd0);
    endtask

    initial begin
        int tq;
        int rd_before;
        checks        = 0;
        failures      = 0;
        rd_count      = 0;
        rst_n         = 1'b0;
        process_done  = 1'b0;
        out_base_addr = '0;
        out_length    = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[12'h010] = 16'd11;
        mem[12'h011] = 16'd22;
        mem[12'h012] = 16'd33;
        mem[12'h013] = 16'd44;
        mem[12'h005] = 16'hBEEF;
        mem[12'hFFE] = 16'hA001;
        mem[12'hFFF] = 16'hA002;
        mem[12'h000] = 16'hA003;
        mem[12'h001] = 16'hA004;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 16'h1000 + 16'(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(com_data_out), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run: 11,22,33,44 from 0x010, first word 3 cycles after start
        launch(12'h010, 13'd4, tq);
        push(16'd11, 1'b0, tq + 2);
        push(16'd22, 1'b0, tq + 3);
        push(16'd33, 1'b0, tq + 4);
        push(16'd44, 1'b1, tq + 5);
        wait_until(tq + 5);
        check("basic_busy_last", 32'(busy), 32'd1);
        wait_until(tq + 6);
        check_idle("basic_end");

        // Single word
        @(negedge clk);
        launch(12'h005, 13'd1, tq);
        push(16'hBEEF, 1'b1, tq + 2);
        wait_until(tq + 3);
        check_idle("single_end");

        // Zero length: one framing cycle, no memory read
        @(negedge clk);
        rd_before = rd_count;
        launch(12'h123, 13'd0, tq);
        push(16'h0000, 1'b1, tq + 2);
        wait_until(tq + 2);
        check("zero_busy_frame", 32'(busy), 32'd1);
        wait_until(tq + 3);
        check_idle("zero_end");
        check("zero_no_reads", 32'(rd_count), 32'(rd_before));

        // Address wrap
        @(negedge clk);
        rd_log.delete();
        launch(12'hFFE, 13'd4, tq);
        push(16'hA001, 1'b0, tq + 2);
        push(16'hA002, 1'b0, tq + 3);
        push(16'hA003, 1'b0, tq + 4);
        push(16'hA004, 1'b1, tq + 5);
        wait_until(tq + 6);
        check_idle("wrap_end");
        check("wrap_rd_count", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            check("wrap_addr0", 32'(rd_log[0]), 32'hFFE);
            check("wrap_addr1", 32'(rd_log[1]), 32'hFFF);
            check("wrap_addr2", 32'(rd_log[2]), 32'h000);
            check("wrap_addr3", 32'(rd_log[3]), 32'h001);
        end

        // process_done while busy is ignored; held high it starts the next
        // run on the first idle cycle after output_write_done.
        @(negedge clk);
        launch(12'h010, 13'd4, tq);
        push(16'd11, 1'b0, tq + 2);
        push(16'd22, 1'b0, tq + 3);
        push(16'd33, 1'b0, tq + 4);
        push(16'd44, 1'b1, tq + 5);
        @(negedge clk);
        out_base_addr = 12'h005;
        out_length    = 13'd1;
        process_done  = 1'b1;
        wait_until(tq + 6);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        wait_until(tq + 7);
        process_done = 1'b0;
        check("b2b_restart_busy", 32'(busy), 32'd1);
        push(16'hBEEF, 1'b1, tq + 9);
        wait_until(tq + 10);
        check_idle("b2b_end");

        // Reset after two of eight words
        @(negedge clk);
        launch(12'h100, 13'd8, tq);
        push(16'h1000, 1'b0, tq + 2);
        push(16'h1001, 1'b0, tq + 3);
        wait_until(tq + 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_data", 32'(com_data_out), 32'd0);
        check("rstmid_rd_en", 32'(mem_rd_en), 32'd0);
        check("rstmid_rd_addr", 32'(mem_rd_addr), 32'd0);
        check_idle("rstmid");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_idle("rstmid_after");

        // Run after reset completes normally
        launch(12'h010, 13'd4, tq);
        push(16'd11, 1'b0, tq + 2);
        push(16'd22, 1'b0, tq + 3);
        push(16'd33, 1'b0, tq + 4);
        push(16'd44, 1'b1, tq + 5);
        wait_until(tq + 6);
        check_idle("post_rst_end");

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Output stage of the multi-core processor top level. Once the cores signal completion, it reads a contiguous block of result words from data memory and streams them one word per clock on `com_data_out`. It drives the `output_write_start` / `output_write_done` framing that the external host samples on each rising clock edge. It sits between the shared data memory read port and the top-level output pins, directly downstream of the core array.

## Interface
- `ADDR_WIDTH`, default 12: data memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 16: word width of memory and output bus.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `process_done`  in  1  cores finished; level or pulse, sampled only in IDLE.
- `out_base_addr`  in  ADDR_WIDTH  first result address; latched on start.
- `out_length`  in  ADDR_WIDTH+1  number of words to emit, 0..2^ADDR_WIDTH; latched on start.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  memory read address.
- `mem_rd_data`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_rd_en`.
- `com_data_out`  out  DATA_WIDTH  streamed result word (registered).
- `output_write_start`  out  1  high on every cycle that `com_data_out` carries a valid word.
- `output_write_done`  out  1  high only on the cycle carrying the final word.
- `busy`  out  1  high from start until the cycle after the last word.

## Operation
- State machine: IDLE, READ, DRAIN.
- **IDLE**
  - When `process_done`=1, latch `out_base_addr` and `out_length`.
  - If length > 0, go to READ. If length = 0, go to DRAIN with an empty pipeline. See the zero-length case below.
- **READ**
  - Assert `mem_rd_en` for exactly N consecutive cycles.
  - `mem_rd_addr` = base + k for word k, computed modulo 2^ADDR_WIDTH.
  - Go to DRAIN after issuing word N-1.
- **DRAIN**
  - Wait for the in-flight reads to emerge, then return to IDLE.
- **Pipeline**
  - The read valid bit is delayed 2 stages: stage 1 aligns with `mem_rd_data`, stage 2 with `com_data_out`.
  - `com_data_out` loads `mem_rd_data` when stage 1 is valid; otherwise it holds its value.
- **Word counting**
  - An issue counter (ADDR_WIDTH+1 bits) tracks reads issued.
  - An emit counter tracks words presented on the output.
  - `output_write_done` is asserted when the emit count reaches N-1 together with `output_write_start`.
- **Zero length**
  - Emit one framing cycle: `output_write_start`=1, `output_write_done`=1, `com_data_out`=0.
  - Issue no memory read.
  - This keeps the host's stop condition reachable.
- **process_done while busy**: ignored; no re-latch and no restart.
- **Back-to-back runs**: a new start is accepted on the first IDLE cycle, i.e. the cycle after `output_write_done`.
- **Reset**
  - Reset asserted in any state returns the block to IDLE on the next edge and discards in-flight reads.
  - No partial frame completes after reset and `output_write_done` is not generated.

## Timing
- Reset values: `com_data_out`=0, `output_write_start`=0, `output_write_done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `busy`=0, state IDLE, counters 0.
- `process_done` sampled high in IDLE at edge T:
  - `busy` is high from T+1.
  - Read k is issued in cycle T+1+k.
  - Word k is on `com_data_out` with `output_write_start`=1 in cycle T+3+k.
- Last word is in cycle T+2+N, with `output_write_done`=1 in that same cycle.
  - Latency is 3 cycles from start to first word.
  - Throughput is 1 word per cycle, with no gaps.
- Cycle T+3+N: `output_write_start`=0, `output_write_done`=0, `busy`=0, state IDLE.
- Zero length: the framing cycle is T+3; `busy` is high T+1..T+3.
- `output_write_start` is never high while `busy` is low.
- `output_write_done` is never high without `output_write_start`.

## Test plan
- **Basic run**: mem[0x010..0x013] = 11, 22, 33, 44; base 0x010, N=4; `process_done` pulse.
  - `com_data_out` = 11, 22, 33, 44 on 4 consecutive cycles starting 3 cycles after the pulse.
  - `output_write_done` high only with 44.
  - `busy` drops the next cycle.
- **Single word**: N=1, base 0x005, mem[0x005] = 0xBEEF.
  - One cycle with `output_write_start`=`output_write_done`=1 and `com_data_out`=0xBEEF.
- **Zero length**: N=0.
  - Exactly one cycle with start=done=1 and data 0.
  - `mem_rd_en` never asserted.
- **Wrap**: ADDR_WIDTH=12, base 0xFFE, N=4.
  - `mem_rd_addr` sequence 0xFFE, 0xFFF, 0x000, 0x001.
  - Data emitted in that order.
- **Busy ignore, then back-to-back**: `process_done` pulsed mid-stream with different base/length.
  - Output unchanged.
  - Holding `process_done` high starts a second run the cycle after the first `output_write_done`.
- **Reset mid-stream**: `rst_n`=0 after 2 of 8 words.
  - Next cycle all outputs are at reset values and `output_write_done` never pulses.
  - A subsequent run completes correctly.
